key_debouncer: RTL and testbench

- Source end of the push-button event path: conditions raw active-low DE-series KEY inputs into clean, debounced levels and single-cycle press/release events.
- Outputs feed event consumers such as button counters, which then increment exactly once per physical press regardless of contact bounce.
- Contains one independent debounce channel per key.
- Sits between the top-level KEY pins and any counter or FSM logic that consumes key events.

---
 rtl/key_debouncer_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 112 +++++++++++
 rtl/key_debouncer.sv | 32 +++
 tb/tb_key_debouncer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debouncer_pkg.sv
// rtl/key_debouncer_pkg.sv - shared types and timing constants for the key debouncer
package key_debouncer_pkg;

  // Per-channel debounce state: settled up/down plus a waiting state for each direction.
  typedef enum logic [1:0] {
    UP        = 2'b00,
    WAIT_DOWN = 2'b01,
    DOWN      = 2'b10,
    WAIT_UP   = 2'b11
  } deb_state_t;

  // Board clock and the debounce window used to derive the default stability count.
  localparam int CLK_HZ      = 50_000_000;
  localparam int DEBOUNCE_MS = 20;

  // The debounced level reads as pressed while settled down or while checking a release.
  function automatic logic state_is_pressed(input deb_state_t st);
    return (st == DOWN) || (st == WAIT_UP);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, debounce FSM and stability counter for one key
module debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse
);

  // Counter value at which a candidate level has been stable long enough.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             pressed_s;

  deb_state_t       state_q;
  deb_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_d;
  logic             release_d;
  logic             level_d;

  // Two-flop synchronizer; both stages idle at 1 so reset looks like a released key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign pressed_s = ~sync2;

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= UP;
      cnt_q         <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  // Next state: any disagreement restarts the wait, a full run of agreement commits the new level.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      UP: begin
        if (pressed_s) begin
          state_d = WAIT_DOWN;
          cnt_d   = '0;
        end
      end
      WAIT_DOWN: begin
        if (!pressed_s) begin
          state_d = UP;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = DOWN;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (!pressed_s) begin
          state_d = WAIT_UP;
          cnt_d   = '0;
        end
      end
      WAIT_UP: begin
        if (pressed_s) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d   = UP;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = UP;
        cnt_d   = '0;
      end
    endcase
    level_d = state_is_pressed(state_d);
  end

endmodule

// File: rtl/key_debouncer.sv
// rtl/key_debouncer.sv - N independent debounced key channels with press/release events
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS,
  parameter int CNT_W         = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  // One self-contained channel per key bit.
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n[i]),
      .key_level    (key_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb/tb_key_debouncer.sv - directed and random checks of key_debouncer against a run-length model
module tb_key_debouncer;

  localparam int NK     = 4;
  localparam int STABLE = 4;
  localparam int CW     = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] press_pulse;
  logic [NK-1:0] release_pulse;

  key_debouncer #(
    .N_KEYS       (NK),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .key_level    (key_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: raw pins pass through a 2-sample delay; a level is accepted once the
  // delayed sample has disagreed with the accepted level for STABLE+1 consecutive edges.
  logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  int            m_run [NK];

  int e_cnt = 0;
  int press_cnt [NK];
  int rel_cnt   [NK];
  int press_edge[NK];
  int rel_edge  [NK];
  logic [NK-1:0] level_or;
  int e0;

  task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    n_tests++;
    assert (got == exp) else begin
      n_fail++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_level = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < NK; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic p;
    for (int i = 0; i < NK; i++) begin
      p = ~m_s2[i];
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      if (p != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == STABLE + 1) begin
          m_level[i] = p;
          if (p) m_press[i] = 1'b1;
          else   m_rel[i]   = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = key_n;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NK; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; press_edge[i] = -1; rel_edge[i] = -1;
    end
    level_or = '0;
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      e_cnt++;
      model_edge();
      @(negedge clk);
      chk("key_level", key_level, m_level);
      chk("press_pulse", press_pulse, m_press);
      chk("release_pulse", release_pulse, m_rel);
      chk("pulse_exclusive", press_pulse & release_pulse, '0);
      level_or |= key_level;
      for (int i = 0; i < NK; i++) begin
        if (press_pulse[i])   begin press_cnt[i]++; press_edge[i] = e_cnt; end
        if (release_pulse[i]) begin rel_cnt[i]++;   rel_edge[i]   = e_cnt; end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    key_n = '1;
    model_reset();
    clear_counts();
    #1;
    chk("reset_level", key_level, '0);
    chk("reset_press", press_pulse, '0);
    chk("reset_release", release_pulse, '0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset = 1'b0;
    tick(3);

    // Clean press then clean release on key 0.
    clear_counts();
    key_n[0] = 1'b0; e0 = e_cnt + 1;
    tick(20);
    chk_int("clean_press_count", press_cnt[0], 1);
    chk_int("clean_press_edge", press_edge[0], e0 + STABLE + 2);
    chk("clean_press_level", key_level, 4'b0001);
    clear_counts();
    key_n[0] = 1'b1; e0 = e_cnt + 1;
    tick(20);
    chk_int("clean_release_count", rel_cnt[0], 1);
    chk_int("clean_release_edge", rel_edge[0], e0 + STABLE + 2);
    chk("clean_release_level", key_level, 4'b0000);

    // Bounce on key 1 before settling low.
    clear_counts();
    for (int b = 0; b < 4; b++) begin
      key_n[1] = b[0];
      tick(2);
    end
    key_n[1] = 1'b0; e0 = e_cnt + 1;
    tick(20);
    chk_int("bounce_press_count", press_cnt[1], 1);
    chk_int("bounce_press_edge", press_edge[1], e0 + STABLE + 2);
    key_n[1] = 1'b1;
    tick(12);

    // Three-cycle glitch on key 2 must be ignored.
    clear_counts();
    key_n[2] = 1'b0;
    tick(3);
    key_n[2] = 1'b1;
    tick(15);
    chk_int("glitch_press_count", press_cnt[2], 0);
    chk_int("glitch_release_count", rel_cnt[2], 0);
    chk("glitch_level_seen", level_or & 4'b0100, '0);

    // All keys pressed together.
    clear_counts();
    key_n = '0; e0 = e_cnt + 1;
    tick(15);
    for (int i = 0; i < NK; i++) begin
      chk_int("simul_press_count", press_cnt[i], 1);
      chk_int("simul_press_edge", press_edge[i], e0 + STABLE + 2);
    end
    chk("simul_level", key_level, 4'b1111);
    key_n = '1;
    tick(15);

    // Reset while key 3 is still being debounced and key 0 is settled down.
    key_n[0] = 1'b0;
    tick(10);
    key_n[3] = 1'b0;
    tick(3);
    chk("pre_reset_level", key_level, 4'b0001);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_level", key_level, '0);
    chk("async_reset_press", press_pulse, '0);
    chk("async_reset_release", release_pulse, '0);
    model_reset();
    @(posedge clk); @(negedge clk);
    #2 reset = 1'b0;
    clear_counts();
    e0 = e_cnt + 1;
    tick(15);
    chk_int("post_reset_press3_count", press_cnt[3], 1);
    chk_int("post_reset_press3_edge", press_edge[3], e0 + STABLE + 2);
    chk_int("post_reset_press0_count", press_cnt[0], 1);
    key_n = '1;
    tick(15);

    // Long hold on key 0.
    clear_counts();
    key_n[0] = 1'b0;
    tick(100);
    chk_int("long_press_count", press_cnt[0], 1);
    chk_int("long_release_count", rel_cnt[0], 0);
    key_n[0] = 1'b1;
    tick(15);

    // Random per-key toggling checked cycle by cycle against the model.
    for (int r = 0; r < 400; r++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 5) == 0) key_n[i] = ~key_n[i];
      tick(1);
    end
    key_n = '1;
    tick(15);
    chk("final_level", key_level, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
